excess3_to_bcd_deserializer: RTL and testbench
==============================================

# excess3_to_bcd_deserializer

Digit-serial Excess-3 to packed-BCD decoder: the receive-side inverse of the team's BCD-to-Excess-3 encoder. It accepts one Excess-3 nibble per handshake, most-significant digit first, and subtracts 3 from each. It assembles `NUM_DIGITS` decoded digits into one packed BCD word and presents it on a valid/ready output port, with an optional invalid-code flag. It sits between a serial Excess-3 digit source (link or encoder output) and downstream BCD arithmetic/display logic.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: digits per output word; legal range is 1..16.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_digit` is valid this cycle.
- `in_ready`, out, 1: block accepts a digit this cycle.
- `in_digit`, in, 4: Excess-3 coded digit.
- `out_valid`, out, 1: `out_bcd` and `out_err` are valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_bcd`, out, 4*NUM_DIGITS: packed BCD. The first digit received occupies the top nibble.
- `out_err`, out, 1: at least one digit in the word was an invalid Excess-3 code.

## Operation
State machine with two states: COLLECT and HOLD.

COLLECT:
- `in_ready`=1, `out_valid`=0.
- A digit is accepted when `in_valid` && `in_ready`.
- On acceptance: `sr <= {sr[4*NUM_DIGITS-5:0], in_digit - 4'd3}` (mod 16), `cnt <= cnt+1`, `err_acc <= err_acc | invalid(in_digit)`.
- When the digit accepted is number `NUM_DIGITS-1` (0-based), go to HOLD.

HOLD:
- `in_ready`=0, `out_valid`=1.
- `out_bcd`=`sr` and `out_err`=`err_acc` are held stable.
- When `out_ready`=1: return to COLLECT and clear `cnt` and `err_acc`. `sr` is not cleared; it is overwritten by the next frame.

Digit coding:
- Valid codes: 4'h3..4'hC, decoding to BCD 0..9.
- Invalid codes: 4'h0, 4'h1, 4'h2, 4'hD, 4'hE, 4'hF. These are still stored as `code-3` mod 16 (4'h0→4'hD, 4'hF→4'hC). They are never silently dropped, and the digit count is unaffected.

`cnt` width is clog2(`NUM_DIGITS`+1). When `NUM_DIGITS`=1, every accepted digit goes straight to HOLD.

## Timing
Reset values:
- state=COLLECT, `cnt`=0, `sr`=0, `err_acc`=0.
- `out_valid`=0, `out_bcd`=0, `out_err`=0.
- `in_ready`=1 from the first cycle after `rst` deasserts.
- Inputs are ignored while `rst`=1.

Latency and throughput:
- `out_valid` rises in the cycle after the last digit of the frame is accepted.
- No input/output overlap: minimum period is `NUM_DIGITS`+1 cycles per word.

Boundary conditions:
- `in_valid` gaps: `cnt` and `sr` are held, with no timeout.
- Backpressure: `out_ready`=0 holds HOLD indefinitely, with outputs bit-stable and `in_ready`=0.
- `out_ready` asserted during COLLECT has no effect.
- Reset mid-frame discards all partial digits and any pending word the same cycle. The next accepted digit starts a new frame.
- `in_valid`=1 in the HOLD-exit cycle is not accepted, because `in_ready` is still 0 that cycle.

## Configuration
Macro: `EXCESS3_ERR_CHECK_EN`.
- Defined: the invalid-code detector is present and `err_acc`/`out_err` behave as above.
- Undefined: the detector and `err_acc` are removed and `out_err` is tied to 0. Decoding is still `code-3` mod 16.

## Structure
Shared package `excess3_pkg`:
- `EXCESS3_OFFSET` = 4'd3.
- `EXCESS3_MIN` = 4'h3 and `EXCESS3_MAX` = 4'hC.
- State enum typedef (COLLECT, HOLD).
- Function `excess3_is_valid`.

One combinational sub-module, `excess3_digit_decode`:
- Input: nibble.
- Outputs: 4-bit BCD digit and `valid` flag.
- It is the direct inverse of the encoder and is reusable elsewhere.

## Test plan
All scenarios use `NUM_DIGITS`=4 and the macro defined unless stated otherwise.
- Digits 4'h4, 4'h5, 4'h6, 4'hC back-to-back, `out_ready`=1 → `out_bcd`=16'h1239, `out_err`=0, `out_valid` high for exactly 1 cycle, the cycle after the 4th accept.
- Same frame with `out_ready`=0 for 5 cycles → `out_valid`=1 and `out_bcd`=16'h1239 stable, `in_ready`=0 throughout; the word is released on `out_ready`=1 and `in_ready`=1 on the next cycle.
- Digits 4'h3, 4'h0, 4'hB, 4'h7 → `out_bcd`=16'h0D84, `out_err`=1. The following frame 4'h3×4 → 16'h0000 with `out_err`=0 (error cleared). With the macro undefined, the first word is the same but `out_err`=0.
- Accept 4'h9, 4'h8, then pulse `rst` for 1 cycle, then 4'h3, 4'h4, 4'h5, 4'h6 → `out_bcd`=16'h0123. No word is emitted for the aborted frame.
- Random `in_valid` gaps over the digit sequence 4'hC, 4'h3, 4'hC, 4'h3 → `out_bcd`=16'h9090, with no extra or lost digits.
- `NUM_DIGITS`=1, digits 4'h7 then 4'h8 → two words, 4'h4 then 4'h5, each with `out_valid` for 1 cycle.

Source files
------------

// File: rtl/excess3_pkg.sv
// rtl/excess3_pkg.sv - shared Excess-3 constants, FSM state type and code check
//
// Purpose : common definitions for the Excess-3 receive path.
// Ports   : none (package).
package excess3_pkg;

  localparam logic [3:0] EXCESS3_OFFSET = 4'd3;
  localparam logic [3:0] EXCESS3_MIN    = 4'h3;
  localparam logic [3:0] EXCESS3_MAX    = 4'hC;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // A code is legal Excess-3 when it maps onto decimal 0..9.
  function automatic logic excess3_is_valid(input logic [3:0] code);
    return (code >= EXCESS3_MIN) && (code <= EXCESS3_MAX);
  endfunction

endpackage

// File: rtl/excess3_digit_decode.sv
// rtl/excess3_digit_decode.sv - combinational Excess-3 to BCD digit decoder
//
// Purpose : inverse of the BCD-to-Excess-3 encoder for a single nibble.
// Ports   : code  - Excess-3 input nibble
//           bcd   - code minus 3, modulo 16 (invalid codes still decode)
//           valid - code lies within 4'h3..4'hC
module excess3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       valid
);

  // Wraps mod 16 on purpose so invalid codes are kept, not dropped.
  assign bcd   = code - EXCESS3_OFFSET;
  assign valid = excess3_is_valid(code);

endmodule

// File: rtl/excess3_to_bcd_deserializer.sv
// rtl/excess3_to_bcd_deserializer.sv - digit-serial Excess-3 to packed BCD word
//
// Purpose : collects NUM_DIGITS Excess-3 digits (MSD first), decodes each and
//           presents the packed BCD word on a valid/ready port.
// Config  : EXCESS3_ERR_CHECK_EN - when defined, out_err flags any invalid
//           code in the word; otherwise out_err is tied low.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - digit handshake, in_digit is the Excess-3 code
//           out_valid/out_ready - word handshake
//           out_bcd             - packed BCD, first digit in the top nibble
//           out_err             - word contains at least one invalid code
module excess3_to_bcd_deserializer
  import excess3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_digit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic                    out_err
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sr, sr_shifted;
  logic [3:0]    digit_bcd;
  logic          digit_valid;
  logic          accept;
  logic          release_word;

  excess3_digit_decode u_decode (
    .code  (in_digit),
    .bcd   (digit_bcd),
    .valid (digit_valid)
  );

  // A one-digit word has nothing to shift; it is simply replaced.
  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign sr_shifted = digit_bcd;
    end else begin : g_multi
      assign sr_shifted = {sr[W-5:0], digit_bcd};
    end
  endgenerate

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    release_word = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (cnt == LAST_IDX)) state_next = HOLD;
      end
      HOLD: begin
        out_valid    = 1'b1;
        release_word = out_ready;
        if (out_ready) state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        sr  <= sr_shifted;
        cnt <= cnt + 1'b1;
      end else if (release_word) begin
        cnt <= '0;
      end
    end
  end

  assign out_bcd = sr;

`ifdef EXCESS3_ERR_CHECK_EN
  logic err_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= 1'b0;
    end else if (accept) begin
      err_acc <= err_acc | ~digit_valid;
    end else if (release_word) begin
      err_acc <= 1'b0;
    end
  end

  assign out_err = err_acc;
`else
  logic unused_valid;
  assign unused_valid = digit_valid;
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_excess3_to_bcd_deserializer.sv
// tb/tb_excess3_to_bcd_deserializer.sv - self-checking bench for the Excess-3 deserializer
module tb_excess3_to_bcd_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  in_digit;
  logic [15:0] out_bcd;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [3:0]  in_digit1;
  logic [3:0]  out_bcd1;

  int checks = 0;
  int errors = 0;

  logic [3:0] dq[$];

  always #5 clk = ~clk;

  excess3_to_bcd_deserializer #(.NUM_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err(out_err)
  );

  excess3_to_bcd_deserializer #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_digit(in_digit1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_bcd(out_bcd1), .out_err(out_err1)
  );

  // Reference: each digit is (code - 3) mod 16, first digit most significant.
  function automatic logic [15:0] model_word();
    int v = 0;
    foreach (dq[i]) v = v * 16 + ((int'(dq[i]) + 13) % 16);
    return 16'(v);
  endfunction

  function automatic logic model_err();
    logic e = 1'b0;
`ifdef EXCESS3_ERR_CHECK_EN
    foreach (dq[i]) if (int'(dq[i]) < 3 || int'(dq[i]) > 12) e = 1'b1;
`endif
    return e;
  endfunction

  // Presents every digit in dq, with optional random idle gaps; returns on the
  // falling edge right after the last digit was accepted.
  task automatic drive_digits(input int gap_max);
    foreach (dq[i]) begin
      int g;
      int t;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_digit = dq[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL drive_in_ready_timeout got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_digit = 4'h5; out_ready = 1'b0;
    in_valid1 = 1'b1; in_digit1 = 4'h5; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    in_valid = 1'b0; in_valid1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after got %b want 0", out_valid); end
    if (out_bcd !== 16'h0000) begin errors++; $display("FAIL reset_out_bcd got %h want 0000", out_bcd); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    dq = '{4'h4, 4'h5, 4'h6, 4'hC};
    drive_digits(0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    if (out_bcd !== 16'h1239) begin errors++; $display("FAIL basic_out_bcd got %h want 1239", out_bcd); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL basic_out_err got %b want 0", out_err); end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    dq = '{4'h4, 4'h5, 4'h6, 4'hC};
    drive_digits(0);
    for (int c = 0; c < 5; c++) begin
      // Offer a digit while holding; it must not be taken.
      in_valid = 1'b1; in_digit = 4'h3;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", c, out_valid); end
      if (out_bcd !== 16'h1239) begin errors++; $display("FAIL bp_out_bcd cyc %0d got %h want 1239", c, out_bcd); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    // A fresh frame proves the HOLD-exit digit was not counted.
    dq = '{4'h4, 4'h4, 4'h4, 4'h4};
    drive_digits(0);
    checks++;
    if (out_bcd !== 16'h1111) begin errors++; $display("FAIL bp_next_frame got %h want 1111", out_bcd); end
    @(negedge clk);
  endtask

  task automatic test_error();
    out_ready = 1'b1;
    dq = '{4'h3, 4'h0, 4'hB, 4'h7};
    drive_digits(0);
    checks += 2;
    if (out_bcd !== 16'h0D84) begin errors++; $display("FAIL err_out_bcd got %h want 0d84", out_bcd); end
    if (out_err !== model_err()) begin errors++; $display("FAIL err_out_err got %b want %b", out_err, model_err()); end
    @(negedge clk);
    dq = '{4'h3, 4'h3, 4'h3, 4'h3};
    drive_digits(0);
    checks += 2;
    if (out_bcd !== 16'h0000) begin errors++; $display("FAIL err_clear_bcd got %h want 0000", out_bcd); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL err_clear_err got %b want 0", out_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    dq = '{4'h9, 4'h8};
    drive_digits(0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_partial got %b want 0", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    dq = '{4'h3, 4'h4, 4'h5, 4'h6};
    drive_digits(0);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_new_valid got %b want 1", out_valid); end
    if (out_bcd !== 16'h0123) begin errors++; $display("FAIL midrst_out_bcd got %h want 0123", out_bcd); end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    dq = '{4'hC, 4'h3, 4'hC, 4'h3};
    drive_digits(4);
    checks++;
    if (out_bcd !== 16'h9090) begin errors++; $display("FAIL gaps_out_bcd got %h want 9090", out_bcd); end
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 25; f++) begin
      int hold;
      out_ready = 1'b0;
      dq.delete();
      for (int k = 0; k < 4; k++) dq.push_back(4'($urandom_range(15, 0)));
      drive_digits(3);
      hold = int'($urandom_range(3, 0));
      for (int c = 0; c <= hold; c++) begin
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_valid f%0d got %b want 1", f, out_valid); end
        if (out_bcd !== model_word()) begin errors++; $display("FAIL rand_bcd f%0d got %h want %h", f, out_bcd, model_word()); end
        if (out_err !== model_err()) begin errors++; $display("FAIL rand_err f%0d got %b want %b", f, out_err, model_err()); end
        if (c == hold) out_ready = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_release f%0d got %b want 0", f, out_valid); end
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] codes[2];
    logic [3:0] want[2];
    codes[0] = 4'h7; codes[1] = 4'h8;
    want[0]  = 4'h4; want[1]  = 4'h5;
    out_ready1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid1 = 1'b1;
      in_digit1 = codes[i];
      @(negedge clk);
      in_valid1 = 1'b0;
      checks += 2;
      if (out_valid1 !== 1'b1) begin errors++; $display("FAIL n1_valid w%0d got %b want 1", i, out_valid1); end
      if (out_bcd1 !== want[i]) begin errors++; $display("FAIL n1_bcd w%0d got %h want %h", i, out_bcd1, want[i]); end
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL n1_one_cycle w%0d got %b want 0", i, out_valid1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_reset_midframe();
    test_gaps();
    test_random_frames();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
